// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width,
// FSM state encodings and the signed-overflow helper.
package add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } add_state_t;

    // Overflow when both operands share a sign and the result sign differs.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_rca_4.sv
// 4-bit ripple-carry adder slice.
// Ports: a, b (4-bit operands), c_in -> sum (4-bit), c_out.
module add_rca_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    always_comb begin
        logic cr;
        cr  = c_in;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ cr;
            cr     = (a[i] & b[i]) | (cr & (a[i] ^ b[i]));
        end
        c_out = cr;
    end

endmodule

// File: rtl/add_seq_w.sv
// W-bit adder that reuses one 4-bit slice, one nibble per cycle, LSB first.
// Ports: clk, rst (sync, active-high), start, a, b, c_in in;
//        sum, c_out, ovf (held results), busy, done (status) out.
module add_seq_w
    import add_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int N  = W / NIB_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    add_state_t state, state_nxt;

    logic [W-1:0]     a_sr, b_sr, sum_sr, sum_nxt;
    logic             cy, a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic [NIB_W-1:0] nib_s;
    logic             nib_c;
    logic             accept, last;

    add_rca_4 u_rca (
        .a     (a_sr[NIB_W-1:0]),
        .b     (b_sr[NIB_W-1:0]),
        .c_in  (cy),
        .sum   (nib_s),
        .c_out (nib_c)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CNT_LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // New nibble enters at the top; after N shifts nibble 0 is at [3:0].
    assign sum_nxt = W'({nib_s, sum_sr} >> NIB_W);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cy     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            cy    <= c_in;
            a_msb <= a[W-1];
            b_msb <= b[W-1];
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> NIB_W;
            b_sr   <= b_sr >> NIB_W;
            cy     <= nib_c;
            sum_sr <= sum_nxt;
            cnt    <= cnt + 1'b1;
            // Results are published only on the completing edge.
            if (last) begin
                sum   <= sum_nxt;
                c_out <= nib_c;
                ovf   <= ovf_calc(a_msb, b_msb, nib_s[NIB_W-1]);
            end
        end
    end

endmodule

// File: tb/tb_add_seq_w.sv
// Self-checking bench for add_seq_w (W=16): table vectors,
// random vectors against an arithmetic model, and handshake corner cases.
module tb_add_seq_w;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst, start, c_in;
    logic [W-1:0] a, b, sum;
    logic         c_out, ovf, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    add_seq_w #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Present operands with start; call at a negedge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc);
        a = ta; b = tb_; c_in = tc; start = 1'b1;
    endtask

    // Starting at the negedge where start is driven, step past the accept
    // edge, then wait for done. lat counts edges after the accept edge.
    task automatic wait_done(output int lat, output int nbusy,
                             input bit hold_chk, input logic [W-1:0] hold);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            if (hold_chk) chk("hold_prev", 32'(sum), 32'(hold));
            @(negedge clk);
            lat++;
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, output logic [W-1:0] s,
                         output logic co, output logic ov);
        logic [W:0] full;
        full = {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc);
        s  = full[W-1:0];
        co = full[W];
        ov = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    endtask

    vec_t vt[4];

    initial begin
        int lat, nb;
        logic [W-1:0] es;
        logic eco, eov;

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b1; a = '1; b = '1; c_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(c_out), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].ci);
            wait_done(lat, nb, 1'b0, '0);
            chk("tbl_lat", 32'(lat), N);
            chk("tbl_busy", 32'(nb), N);
            chk("tbl_sum", 32'(sum), 32'(vt[i].s));
            chk("tbl_cout", 32'(c_out), 32'(vt[i].co));
            chk("tbl_ovf", 32'(ovf), 32'(vt[i].ov));
            @(negedge clk);
            chk("tbl_done_pulse", 32'(done), 0);
            chk("tbl_sum_held", 32'(sum), 32'(vt[i].s));
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            model(ra, rb, rc, es, eco, eov);
            issue(ra, rb, rc);
            wait_done(lat, nb, 1'b0, '0);
            chk("rnd_sum", 32'(sum), 32'(es));
            chk("rnd_cout", 32'(c_out), 32'(eco));
            chk("rnd_ovf", 32'(ovf), 32'(eov));
            if (i % 3 == 0) @(negedge clk);
        end
        @(negedge clk);

        // Start during RUN is ignored.
        issue(16'h0F0F, 16'h00F1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy1", 32'(busy), 1);
        @(negedge clk);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        lat++;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("ign_lat", 32'(lat), N);
        chk("ign_sum", 32'(sum), 32'h1000);
        chk("ign_cout", 32'(c_out), 0);
        @(negedge clk);
        chk("ign_idle", 32'(busy), 0);

        // Reset in the second RUN cycle abandons the add.
        issue(16'hAAAA, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_busy", 32'(busy), 0);
        chk("rr_done", 32'(done), 0);
        chk("rr_sum", 32'(sum), 0);
        chk("rr_cout", 32'(c_out), 0);
        @(negedge clk);
        chk("rr_still_idle", 32'(busy), 0);
        issue(16'h0001, 16'h0002, 1'b0);
        wait_done(lat, nb, 1'b0, '0);
        chk("rr_sum2", 32'(sum), 32'h0003);
        chk("rr_lat2", 32'(lat), N);
        @(negedge clk);

        // Back-to-back: start held in the DONE cycle.
        issue(16'h1234, 16'h4321, 1'b0);
        wait_done(lat, nb, 1'b0, '0);
        chk("b2b_first", 32'(sum), 32'h5555);
        issue(16'h0000, 16'h0000, 1'b1);
        wait_done(lat, nb, 1'b1, 16'h5555);
        chk("b2b_lat", 32'(lat), N);
        chk("b2b_busy", 32'(nb), N);
        chk("b2b_sum", 32'(sum), 32'h0001);
        chk("b2b_cout", 32'(c_out), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/add_seq_w.md
Name: add_seq_w

Overview:
- Multi-cycle W-bit adder that feeds the 4-bit ripple-carry slice add_rca_4 one nibble per cycle and registers the carry between nibbles.
- Adds wide operands with a single 4-bit slice, LSB nibble first, and uses a start/busy/done handshake.
- Sits in the datapath between the operand registers and the result consumer.

Parameters:
- W, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
- N, W/4, derived: number of nibbles, which is also the number of RUN cycles. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  operand A; captured on an accepted start.
- b  input  W  operand B; captured on an accepted start.
- c_in  input  1  carry-in to nibble 0; captured on an accepted start.
- sum  output  W  result; valid while done=1 and held until the next accepted start.
- c_out  output  1  carry out of nibble N-1; same validity as sum.
- ovf  output  1  two's-complement overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
- busy  output  1  high while the add is in progress (RUN).
- done  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset: on a clk edge with rst=1:
  - state=IDLE; sum=0, c_out=0, ovf=0, busy=0, done=0.
  - Operand shift registers, carry register and nibble counter all cleared.
  - rst overrides start on the same edge.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a, b and c_in into shift registers A_sr, B_sr and carry register cy.
  - Latch a[W-1] and b[W-1] separately for ovf.
  - cnt=0, go to RUN. busy=1 from this edge.
- RUN, every cycle:
  - add_rca_4 adds A_sr[3:0] + B_sr[3:0] + cy.
  - At the edge: cy takes the slice carry-out. The slice sum is shifted into sum_sr from the MSB side, so after N shifts nibble 0 sits at [3:0].
  - A_sr and B_sr shift right by 4. cnt increments.
- RUN, when cnt==N-1:
  - That edge writes the final nibble; sum and c_out update from sum_sr and cy; ovf is computed.
  - Go to DONE. busy=0, done=1.
- DONE lasts one cycle: done=1, busy=0.
  - start=1: accepted exactly as in IDLE, so back-to-back adds need no idle gap. Go to RUN.
  - start=0: go to IDLE.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+N, and busy=1 between edges k and k+N. For W=16 the result appears 4 cycles after start.
- start while in RUN: ignored. No queueing; operands and in-flight state are unaffected.
- Output stability: sum, c_out and ovf change only at the completing edge or at reset. They are never visible mid-computation.
- a, b and c_in are don't-care except on accepting edges.
- Arithmetic is unsigned modulo 2^W, with c_out as bit W. ovf gives the signed interpretation of the same add.
- Counter width is $clog2(N), minimum 1 bit. When W=4, RUN lasts exactly one cycle.
- rst during RUN: the operation is abandoned, outputs return to reset values on that edge, and the next start behaves normally.

Decomposition:
- Shared package add_pkg:
  - NIB_W=4.
  - State encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Helper function for the ovf term.
- One sub-module: the existing add_rca_4 instantiated once as the per-cycle nibble adder. Its ports are c_out, sum[3:0], a[3:0], b[3:0], c_in. No other hierarchy.

Test Plan:
- W=16, a=0x1234, b=0x4321, c_in=0, start pulse -> busy high 4 cycles, then done=1 for 1 cycle with sum=0x5555, c_out=0, ovf=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Exercises carry ripple through all 4 nibbles via cy.
- a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
- Start a=0x0F0F, b=0x00F1; assert start again in RUN cycle 2 with a=0xFFFF, b=0xFFFF -> second start ignored, result 0x1000, c_out=0.
- rst=1 in RUN cycle 2 of an add -> next cycle busy=0, done=0, sum=0, c_out=0. A following start with a=0x0001, b=0x0002 returns 0x0003.
- Back-to-back: start held during the DONE cycle with a=0x0000, b=0x0000, c_in=1 -> no IDLE gap, done 4 cycles later with sum=0x0001, c_out=0. The first result stays held until that completion.
